// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_pkg
// Purpose  : Shared definitions for the PWM capture block: default counter
//            width and the capture FSM state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pwm_capture_pkg;

  localparam int c_CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_in_cond
// Purpose  : Input conditioning for pwm_capture: synchronizer, optional glitch
//            filter (macro PWM_CAP_FILTER_EN) and edge detection.
// Ports    : clk     in  clock
//            rst     in  synchronous active-high reset
//            i_pwm   in  asynchronous PWM pin
//            o_lvl   out conditioned level
//            o_rise  out 1-cycle rising-edge strobe
//            o_fall  out 1-cycle falling-edge strobe
// Revision : 1.0  initial release
// ============================================================================
module pwm_capture_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pwm,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  // Counter is sized for the longer (filtered) settle time in both builds.
  localparam int c_SETTLE_W = $clog2(SYNC_STAGES + FILT_LEN + 2);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_lvl;
  logic                   r_lvl_d;
  logic [c_SETTLE_W-1:0]  r_settle;
  logic                   w_ready;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
  localparam int c_FCNT_W = $clog2(FILT_LEN + 1);
  localparam int c_SETTLE = SYNC_STAGES + FILT_LEN + 1;

  logic                r_lvl;
  logic [c_FCNT_W-1:0] r_fcnt;

  // Level flips only after the synced input has disagreed with it for
  // FILT_LEN consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl  <= 1'b0;
      r_fcnt <= '0;
    end else if (w_sync == r_lvl) begin
      r_fcnt <= '0;
    end else if (r_fcnt == c_FCNT_W'(FILT_LEN - 1)) begin
      r_lvl  <= w_sync;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end

  assign w_lvl = r_lvl;
`else
  localparam int c_SETTLE = SYNC_STAGES + 1;

  assign w_lvl = w_sync;
`endif

  // Reset clears the pipeline to 0; if the pin is high the level then climbs
  // back to 1, which is not a real pin edge. Edges are masked until the
  // pipeline (and the delayed level) has refilled with the true pin value.
  always_ff @(posedge clk) begin
    if (rst)           r_settle <= c_SETTLE_W'(c_SETTLE);
    else if (!w_ready) r_settle <= r_settle - 1'b1;
  end

  assign w_ready = (r_settle == '0);

  always_ff @(posedge clk) begin
    if (rst) r_lvl_d <= 1'b0;
    else     r_lvl_d <= w_lvl;
  end

  assign o_lvl  = w_lvl;
  assign o_rise = w_ready &  w_lvl & ~r_lvl_d;
  assign o_fall = w_ready & ~w_lvl &  r_lvl_d;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : PWM input capture. Measures period (rising to rising) and high
//            time (rising to falling) of an external PWM signal in clk cycles.
//            Optional glitch filter: define PWM_CAP_FILTER_EN.
// Ports    : clk          in  clock
//            rst          in  synchronous active-high reset
//            i_en         in  capture enable (low = idle, results held)
//            i_pwm_in     in  asynchronous PWM input
//            o_period     out last complete period
//            o_high_time  out high time of that same period
//            o_meas_valid out 1-cycle strobe when results update
//            o_timeout    out sticky: no edge for 2^CNT_W-1 cycles
//            o_in_level   out conditioned input level
// Revision : 1.0  initial release
// ============================================================================
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = c_CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_meas_valid,
  output logic             o_timeout,
  output logic             o_in_level
);

  logic             w_lvl;
  logic             w_rise;
  logic             w_fall;
  logic             w_sat;
  cap_state_e       r_state;
  cap_state_e       w_state_nxt;
  logic             w_publish;
  logic             w_cap_high;
  logic             w_to_set;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_q;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;

  pwm_capture_in_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_in_cond (
    .clk    (clk),
    .rst    (rst),
    .i_pwm  (i_pwm_in),
    .o_lvl  (w_lvl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_sat = (r_cnt == {CNT_W{1'b1}});

  // Edges take priority over saturation, so a measurement that lands exactly
  // on the counter limit is still reported rather than timing out.
  always_comb begin
    w_state_nxt = r_state;
    w_publish   = 1'b0;
    w_cap_high  = 1'b0;
    w_to_set    = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) w_state_nxt = ST_HIGH;
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_state_nxt = ST_LOW;
            w_cap_high  = 1'b1;
          end else if (w_sat) begin
            w_state_nxt = ST_IDLE;
            w_to_set    = 1'b1;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
            w_publish   = 1'b1;
          end else if (w_sat) begin
            w_state_nxt = ST_IDLE;
            w_to_set    = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counter restarts at 1 on every rise, so the value seen at the next rise
  // is the full period and the value at the fall is the high time.
  always_ff @(posedge clk) begin
    if (rst || !i_en)                    r_cnt <= '0;
    else if (w_rise)                     r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    else if (r_state != ST_IDLE && !w_sat) r_cnt <= r_cnt + 1'b1;
  end

  // High time is staged internally and only published alongside its own
  // period, so the output pair always describes one complete cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_q  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (w_cap_high) r_high_q <= r_cnt;
      if (w_publish) begin
        r_period  <= r_cnt;
        r_high    <= r_high_q;
        r_timeout <= 1'b0;
      end else if (w_to_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_period     = r_period;
  assign o_high_time  = r_high;
  assign o_meas_valid = r_valid;
  assign o_timeout    = r_timeout;
  assign o_in_level   = w_lvl;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Directed self-checking bench for pwm_capture.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

  logic        clk;
  logic        rst;
  logic        i_en;
  logic        i_pwm_in;
  logic [15:0] o_period;
  logic [15:0] o_high_time;
  logic        o_meas_valid;
  logic        o_timeout;
  logic        o_in_level;

  int n_vec;
  int n_bad;
  int cyc;
  int q_per[$];
  int q_hi[$];
  int q_cyc[$];

  pwm_capture #(
    .CNT_W       (16),
    .SYNC_STAGES (2),
    .FILT_LEN    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .i_pwm_in     (i_pwm_in),
    .o_period     (o_period),
    .o_high_time  (o_high_time),
    .o_meas_valid (o_meas_valid),
    .o_timeout    (o_timeout),
    .o_in_level   (o_in_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every published result, sampled away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_meas_valid === 1'b1) begin
      q_per.push_back(int'(o_period));
      q_hi.push_back(int'(o_high_time));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl, input int n);
    i_pwm_in = lvl;
    tick(n);
  endtask

  task automatic pwm(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic clr_log();
    q_per.delete();
    q_hi.delete();
    q_cyc.delete();
  endtask

  task automatic chk_last(input string tag, input int per, input int hi);
    if (q_per.size() > 0) begin
      chk({tag, "_period"}, q_per[q_per.size()-1], per);
      chk({tag, "_high"}, q_hi[q_hi.size()-1], hi);
    end else begin
      chk({tag, "_present"}, 0, 1);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    cyc      = 0;
    rst      = 1'b1;
    i_en     = 1'b0;
    i_pwm_in = 1'b0;
    tick(3);

    // Reset state
    chk("rst_period", o_period, 0);
    chk("rst_high", o_high_time, 0);
    chk("rst_valid", o_meas_valid, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_level", o_in_level, 0);

    rst  = 1'b0;
    i_en = 1'b1;
    tick(5);

    // 1: 3/7 stream; first rise only arms, so 5 rises give 4 results
    clr_log();
    for (int i = 0; i < 5; i++) pwm(3, 7);
    chk("t1_count", q_per.size(), 4);
    chk_last("t1", 10, 3);
    if (q_cyc.size() >= 2) chk("t1_spacing", q_cyc[q_cyc.size()-1] - q_cyc[q_cyc.size()-2], 10);
    chk("t1_valid_low", o_meas_valid, 0);

    // 2: duty changes at a period boundary; pairs never mixed
    clr_log();
    for (int i = 0; i < 4; i++) pwm(7, 3);
    chk("t2_count", q_per.size(), 4);
    if (q_per.size() >= 2) begin
      chk("t2_first_period", q_per[0], 10);
      chk("t2_first_high", q_hi[0], 3);
      chk("t2_second_period", q_per[1], 10);
      chk("t2_second_high", q_hi[1], 7);
    end
    chk_last("t2", 10, 7);

    // 3: input stuck high -> timeout at counter saturation
    drive(1'b1, 20);
    clr_log();
    chk("t3_no_timeout_early", o_timeout, 0);
    drive(1'b1, 65000);
    chk("t3_no_timeout_65k", o_timeout, 0);
    drive(1'b1, 5000);
    chk("t3_timeout", o_timeout, 1);
    chk("t3_level", o_in_level, 1);
    chk("t3_no_valid", q_per.size(), 0);
    chk("t3_period_held", o_period, 10);
    drive(1'b0, 10);
    pwm(3, 7);
    chk("t3_timeout_until_result", o_timeout, 1);
    chk("t3_armed_only", q_per.size(), 0);
    pwm(3, 7);
    pwm(3, 7);
    chk("t3_timeout_cleared", o_timeout, 0);
    chk("t3_restart_count", q_per.size(), 2);
    chk_last("t3", 10, 3);

    // 4: reset pulsed in the high phase
    i_pwm_in = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk("t4_period", o_period, 0);
    chk("t4_high", o_high_time, 0);
    chk("t4_valid", o_meas_valid, 0);
    chk("t4_timeout", o_timeout, 0);
    chk("t4_level", o_in_level, 0);
    rst = 1'b0;
    clr_log();
    drive(1'b1, 1);
    drive(1'b0, 7);
    pwm(3, 7);
    chk("t4_armed_only", q_per.size(), 0);
    pwm(3, 7);
    chk("t4_count", q_per.size(), 1);
    chk_last("t4", 10, 3);

    // 5: enable dropped in the low phase for 20 cycles
    drive(1'b1, 3);
    drive(1'b0, 3);
    clr_log();
    i_en = 1'b0;
    drive(1'b0, 4);
    pwm(3, 7);
    drive(1'b1, 3);
    drive(1'b0, 3);
    chk("t5_no_valid", q_per.size(), 0);
    chk("t5_period_held", o_period, 10);
    chk("t5_high_held", o_high_time, 3);
    chk("t5_timeout_held", o_timeout, 0);
    i_en = 1'b1;
    drive(1'b0, 4);
    pwm(3, 7);
    chk("t5_armed_only", q_per.size(), 0);
    pwm(3, 7);
    chk("t5_count", q_per.size(), 1);
    chk_last("t5", 10, 3);

    // 6: 2-cycle glitch inside a long low phase
    pwm(5, 15);
    clr_log();
    drive(1'b1, 5);
    drive(1'b0, 5);
    drive(1'b1, 2);
    drive(1'b0, 8);
    pwm(5, 15);
`ifdef PWM_CAP_FILTER_EN
    chk("t6_count", q_per.size(), 2);
    chk_last("t6", 20, 5);
`else
    chk("t6_count", q_per.size(), 3);
    chk_last("t6", 10, 2);
`endif
    chk("t6_level", o_in_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
